// File: rtl/ddc_pkg.sv
// Shared types for the ddc tone loader: phase width, loader state encoding and
// the {pinc, poff} table entry.
package ddc_pkg;

  localparam int PHASE_W = 20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    EMIT = 3'd2,
    GAP  = 3'd3,
    FIN  = 3'd4
  } loader_state_t;

  typedef struct packed {
    logic [PHASE_W-1:0] pinc;
    logic [PHASE_W-1:0] poff;
  } tone_entry_t;

endpackage

// File: rtl/ddc_tone_loader_if.sv
// Control-register side and ddc_quad side of the tone loader, bundled as one bus.
// Handshake: cfg_valid, done, wr_err and resync_out are single-cycle strobes with no
// back-pressure; cfg_ch/cfg_pinc/cfg_poff are only meaningful while cfg_valid is high.
interface ddc_tone_loader_if #(
  parameter int N_CH    = 4,
  parameter int PHASE_W = ddc_pkg::PHASE_W
);
  localparam int CH_W = $clog2(N_CH);

  logic                  tbl_we;
  logic [CH_W-1:0]       tbl_addr;
  logic [PHASE_W-1:0]    tbl_pinc;
  logic [PHASE_W-1:0]    tbl_poff;
  logic                  start;
  logic [N_CH-1:0]       ch_mask;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  wr_err;
  logic [CH_W-1:0]       cfg_ch;
  logic [PHASE_W-1:0]    cfg_pinc;
  logic [PHASE_W-1:0]    cfg_poff;
  logic                  cfg_valid;
  logic                  resync_out;
  ddc_pkg::loader_state_t dbg_state;

  modport master (
    output tbl_we, tbl_addr, tbl_pinc, tbl_poff, start, ch_mask, abort,
    input  busy, done, wr_err, cfg_ch, cfg_pinc, cfg_poff, cfg_valid, resync_out, dbg_state
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_pinc, tbl_poff, start, ch_mask, abort,
    output busy, done, wr_err, cfg_ch, cfg_pinc, cfg_poff, cfg_valid, resync_out, dbg_state
  );

endinterface

// File: rtl/ddc_tone_table.sv
// N_CH-entry tone table: one write port and a read register that only updates on
// rd_en, so its output doubles as the held cfg_pinc/cfg_poff value.
module ddc_tone_table
  import ddc_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [CH_W-1:0] wr_addr,
  input  tone_entry_t     wr_data,
  input  logic            rd_en,
  input  logic [CH_W-1:0] rd_addr,
  output tone_entry_t     rd_data
);

  tone_entry_t mem [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ddc_tone_loader.sv
// Tone-table sequencer: replays masked table entries as cfg_valid strobes with a settle gap.
// DDC_LOADER_AUTO_RESYNC_EN: when defined, resync_out pulses in the FIN cycle.
module ddc_tone_loader
  import ddc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PHASE_W    = ddc_pkg::PHASE_W,
  parameter int GAP_CYCLES = 3
) (
  input  logic dev_clk,
  input  logic dev_resetn,
  ddc_tone_loader_if.slave bus
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  loader_state_t     state, state_nx;
  logic [N_CH-1:0]   mask_q;
  logic [CH_W-1:0]   ch_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CH_W-1:0]   cfg_ch_q;
  logic              wr_err_q;
  logic              last_ch, mask_hit, gap_end, rd_en, tbl_wr_en;
  tone_entry_t       wr_entry, rd_entry;

  assign last_ch   = (ch_idx == LAST_CH);
  assign mask_hit  = mask_q[ch_idx];
  assign gap_end   = (gap_cnt == GAP_W'(1));
  assign rd_en     = (state == SCAN) && mask_hit && !bus.abort;
  assign tbl_wr_en = bus.tbl_we && (state == IDLE);
  assign wr_entry  = '{pinc: bus.tbl_pinc, poff: bus.tbl_poff};

  ddc_tone_table #(.N_CH(N_CH)) u_table (
    .clk     (dev_clk),
    .rst_n   (dev_resetn),
    .we      (tbl_wr_en),
    .wr_addr (bus.tbl_addr),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_addr (ch_idx),
    .rd_data (rd_entry)
  );

  always_ff @(posedge dev_clk or negedge dev_resetn) begin
    if (!dev_resetn) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start && !bus.abort) state_nx = SCAN;
      SCAN: begin
        if (bus.abort)    state_nx = IDLE;
        else if (mask_hit) state_nx = EMIT;
        else if (last_ch)  state_nx = FIN;
        else               state_nx = SCAN;
      end
      EMIT: begin
        if (bus.abort)            state_nx = IDLE;
        else if (GAP_CYCLES != 0) state_nx = GAP;
        else if (last_ch)         state_nx = FIN;
        else                      state_nx = SCAN;
      end
      GAP: begin
        if (bus.abort)    state_nx = IDLE;
        else if (gap_end) state_nx = last_ch ? FIN : SCAN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Every entry into SCAN from a busy state advances to the next channel.
  always_ff @(posedge dev_clk or negedge dev_resetn) begin
    if (!dev_resetn) begin
      mask_q   <= '0;
      ch_idx   <= '0;
      gap_cnt  <= '0;
      cfg_ch_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (state == IDLE && state_nx == SCAN) begin
        mask_q <= bus.ch_mask;
        ch_idx <= '0;
      end else if (state != IDLE && state_nx == SCAN) begin
        ch_idx <= ch_idx + CH_W'(1);
      end
      if (state == EMIT)     gap_cnt <= GAP_W'(GAP_CYCLES);
      else if (state == GAP) gap_cnt <= gap_cnt - GAP_W'(1);
      if (rd_en) cfg_ch_q <= ch_idx;
      wr_err_q <= bus.tbl_we && (state != IDLE);
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.cfg_valid = (state == EMIT) && !bus.abort;
    bus.done      = (state == FIN) && !bus.abort;
`ifdef DDC_LOADER_AUTO_RESYNC_EN
    bus.resync_out = (state == FIN) && !bus.abort;
`else
    bus.resync_out = 1'b0;
`endif
  end

  assign bus.cfg_ch    = cfg_ch_q;
  assign bus.cfg_pinc  = rd_entry.pinc;
  assign bus.cfg_poff  = rd_entry.poff;
  assign bus.wr_err    = wr_err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ddc_tone_loader.sv
// Randomised bench for ddc_tone_loader against a cycle-schedule model of the load sequence.
module tb_ddc_tone_loader;

  localparam int N_CH = 4;
  localparam int PW   = 20;
  localparam int GAP  = 3;
`ifdef DDC_LOADER_AUTO_RESYNC_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic dev_clk = 1'b0;
  logic dev_resetn = 1'b0;

  ddc_tone_loader_if #(.N_CH(N_CH), .PHASE_W(PW)) bus ();

  ddc_tone_loader #(.N_CH(N_CH), .PHASE_W(PW), .GAP_CYCLES(GAP)) dut (
    .dev_clk    (dev_clk),
    .dev_resetn (dev_resetn),
    .bus        (bus)
  );

  always #5 dev_clk = ~dev_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] ref_pinc [N_CH];
  logic [PW-1:0] ref_poff [N_CH];
  logic [41:0]   exp_q [$];
  logic [41:0]   last_cfg = '0;
  bit            known = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Schedule model: a masked channel costs SCAN+EMIT+GAP cycles, an unmasked one a single SCAN.
  function automatic int seq_len(input logic [3:0] mask);
    int cur = 1;
    for (int i = 0; i < N_CH; i++) cur += mask[i] ? (2 + GAP) : 1;
    return cur;
  endfunction

  task automatic write_tbl(input int addr, input logic [PW-1:0] pi, input logic [PW-1:0] po);
    @(negedge dev_clk);
    bus.tbl_we = 1'b1; bus.tbl_addr = 2'(addr); bus.tbl_pinc = pi; bus.tbl_poff = po;
    ref_pinc[addr] = pi; ref_poff[addr] = po;
    @(negedge dev_clk);
    check_eq("wr_err_idle", bus.wr_err, 0);
    bus.tbl_we = 1'b0;
  endtask

  task automatic run_seq(input logic [3:0] mask, input int abort_at, input int we_at,
                         input int restart_at, input bit same_we);
    int emit_at [64];
    int done_c, cur, a;
    bit act;
    logic [41:0] item;
    for (int c = 0; c < 64; c++) emit_at[c] = -1;
    cur = 1;
    for (int i = 0; i < N_CH; i++) begin
      if (mask[i]) begin emit_at[cur+1] = i; cur += 2 + GAP; end
      else cur += 1;
    end
    done_c = seq_len(mask);
    @(negedge dev_clk);
    if (same_we) begin
      a = $urandom_range(0, N_CH-1);
      bus.tbl_we = 1'b1; bus.tbl_addr = 2'(a);
      bus.tbl_pinc = PW'($urandom); bus.tbl_poff = PW'($urandom);
      ref_pinc[a] = bus.tbl_pinc; ref_poff[a] = bus.tbl_poff;
    end
    bus.start = 1'b1; bus.ch_mask = mask; bus.abort = 1'b0;
    exp_q.delete();
    for (int c = 1; c < 64; c++)
      if (emit_at[c] >= 0 && (abort_at == 0 || c < abort_at))
        exp_q.push_back({2'(emit_at[c]), ref_pinc[emit_at[c]], ref_poff[emit_at[c]]});
    for (int cyc = 1; cyc <= done_c + 2; cyc++) begin
      @(negedge dev_clk);
      bus.start    = (cyc == restart_at);
      bus.ch_mask  = (cyc == restart_at) ? 4'($urandom) : mask;
      bus.tbl_we   = (cyc == we_at);
      bus.tbl_addr = 2'd2;
      bus.tbl_pinc = PW'($urandom);
      bus.tbl_poff = PW'($urandom);
      bus.abort    = (cyc == abort_at);
      #1;
      act = (abort_at == 0) || (cyc < abort_at);
      check_eq("cfg_valid", bus.cfg_valid, (emit_at[cyc] >= 0) && act);
      check_eq("busy", bus.busy, (cyc <= done_c) && (abort_at == 0 || cyc <= abort_at));
      check_eq("done", bus.done, (cyc == done_c) && act);
      check_eq("resync_out", bus.resync_out, RS_EN && (cyc == done_c) && act);
      check_eq("wr_err", bus.wr_err, (we_at != 0) && (cyc == we_at + 1));
      if (bus.cfg_valid && emit_at[cyc] >= 0 && act) begin
        check_eq("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          item = exp_q.pop_front();
          check_eq("cfg_strobe", {bus.cfg_ch, bus.cfg_pinc, bus.cfg_poff}, item);
          last_cfg = item; known = 1'b1;
        end
      end else if (emit_at[cyc] >= 0 && cyc == abort_at) begin
        known = 1'b0;
      end else if (known) begin
        check_eq("cfg_hold", {bus.cfg_ch, bus.cfg_pinc, bus.cfg_poff}, last_cfg);
      end
    end
    check_eq("sb_empty", exp_q.size(), 0);
    @(negedge dev_clk);
    bus.start = 1'b0; bus.tbl_we = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    int m, d, ab, lim, we, rs;
    bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_pinc = '0; bus.tbl_poff = '0;
    bus.start = 1'b0; bus.ch_mask = '0; bus.abort = 1'b0;
    for (int i = 0; i < N_CH; i++) begin ref_pinc[i] = '0; ref_poff[i] = '0; end
    #12;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_cfg", {bus.cfg_valid, bus.done, bus.wr_err, bus.resync_out,
                         bus.cfg_ch, bus.cfg_pinc, bus.cfg_poff}, 0);
    @(negedge dev_clk);
    dev_resetn = 1'b1;

    for (int i = 0; i < N_CH; i++) write_tbl(i, PW'(32'h00100 * (i + 1)), PW'(32'h00010 * i));
    run_seq(4'hF, 0, 0, 0, 1'b0);
    run_seq(4'b1010, 0, 0, 0, 1'b0);
    run_seq(4'h0, 0, 0, 0, 1'b0);
    run_seq(4'hF, 8, 4, 0, 1'b0);
    run_seq(4'hF, 0, 0, 0, 1'b0);
    run_seq(4'b0101, 0, 0, 5, 1'b1);

    repeat (24) begin
      if ($urandom_range(0, 3) == 0)
        write_tbl($urandom_range(0, N_CH-1), PW'($urandom), PW'($urandom));
      m   = $urandom_range(0, 15);
      d   = seq_len(4'(m));
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, d) : 0;
      lim = (ab != 0) ? ab : d;
      we  = $urandom_range(0, 1) ? $urandom_range(1, lim) : 0;
      rs  = $urandom_range(0, 1) ? $urandom_range(1, lim) : 0;
      run_seq(4'(m), ab, we, rs, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a load sequence.
    @(negedge dev_clk);
    bus.start = 1'b1; bus.ch_mask = 4'hF;
    @(negedge dev_clk);
    bus.start = 1'b0;
    repeat (6) @(negedge dev_clk);
    dev_resetn = 1'b0;
    #1;
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_outs", {bus.cfg_valid, bus.done, bus.wr_err, bus.resync_out,
                             bus.cfg_ch, bus.cfg_pinc, bus.cfg_poff}, 0);
    for (int i = 0; i < N_CH; i++) begin ref_pinc[i] = '0; ref_poff[i] = '0; end
    last_cfg = '0; known = 1'b1;
    @(negedge dev_clk);
    dev_resetn = 1'b1;
    repeat (5) begin
      @(negedge dev_clk);
      #1;
      check_eq("postrst_busy", bus.busy, 0);
      check_eq("postrst_valid", bus.cfg_valid, 0);
      check_eq("postrst_done", bus.done, 0);
    end
    run_seq(4'b0110, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
